// File: rtl/id_decode_stage_pkg.sv
// Shared definitions for the ID stage: immediate-select codes, RV32 major opcodes
// (inst[6:2]) and the elastic-buffer state encoding.
package id_decode_stage_pkg;

  localparam int REG_WIDTH = 32;
  localparam int IMMSEL_W  = 3;
  localparam logic [REG_WIDTH-1:0] ZERO_WORD = '0;

  typedef enum logic [IMMSEL_W-1:0] {
    IMMSEL_NONE = 3'd0,
    IMMSEL_I    = 3'd1,
    IMMSEL_S    = 3'd2,
    IMMSEL_B    = 3'd3,
    IMMSEL_J    = 3'd4,
    IMMSEL_U    = 3'd5
  } immsel_e;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/id_decode_stage_immgen.sv
// Immediate generator: builds the sign-extended immediate for the selected format.
module id_decode_stage_immgen
  import id_decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  immsel_e         immsel,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    imm32 = '0;
    unique case (immsel)
      IMMSEL_I: imm32 = {{20{inst[31]}}, inst[31:20]};
      IMMSEL_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMMSEL_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMMSEL_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMMSEL_U: imm32 = {inst[31:12], 12'b0};
      default:  imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_decode_stage.sv
// Instruction-decode stage: decodes on capture into a 2-entry elastic buffer
// (output register + skid) so that id_ready_o comes straight from registered state.
module id_decode_stage
  import id_decode_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_valid_i,
  input  logic [31:0]         if_inst_i,
  input  logic [XLEN-1:0]     if_pc_i,
  output logic                id_ready_o,
  input  logic                flush_i,
  input  logic                ex_ready_i,
  output logic                ex_valid_o,
  output logic [XLEN-1:0]     ex_pc_o,
  output logic [XLEN-1:0]     ex_imm_o,
  output logic [IMMSEL_W-1:0] ex_immsel_o,
  output logic [4:0]          ex_rs1_o,
  output logic [4:0]          ex_rs2_o,
  output logic [4:0]          ex_rd_o,
  output logic                ex_rd_we_o,
  output logic                ex_illegal_o,
  output logic [CNT_W-1:0]    bp_cnt_o
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    immsel_e         immsel;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;
  } ex_payload_t;

  state_e          state_q, state_d;
  logic            ex_valid, id_ready;
  logic            acc, pop;
  logic            load_out, load_skid;

  logic [31:0]     skid_inst_q;
  logic [XLEN-1:0] skid_pc_q;
  logic [31:0]     cap_inst;
  logic [XLEN-1:0] cap_pc;
  immsel_e         cap_immsel;
  logic            cap_rd_we, cap_illegal;
  logic [XLEN-1:0] cap_imm;
  ex_payload_t     cap_payload, out_q;
  logic [CNT_W-1:0] bp_cnt_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (acc) state_d = ST_ONE;
        ST_ONE: begin
          if (acc && !pop)      state_d = ST_TWO;
          else if (!acc && pop) state_d = ST_EMPTY;
        end
        ST_TWO:   if (pop) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    ex_valid  = (state_q != ST_EMPTY);
    id_ready  = (state_q != ST_TWO);
    acc       = if_valid_i && id_ready && !flush_i;
    pop       = ex_valid && ex_ready_i;
    load_out  = 1'b0;
    load_skid = 1'b0;
    if (!flush_i) begin
      unique case (state_q)
        ST_EMPTY: load_out = acc;
        ST_ONE: begin
          load_out  = acc && pop;
          load_skid = acc && !pop;
        end
        ST_TWO:   load_out = pop;
        default:  load_out = 1'b0;
      endcase
    end
  end

  // In TWO the skid is the oldest pending instruction and must refill the output first.
  assign cap_inst = (state_q == ST_TWO) ? skid_inst_q : if_inst_i;
  assign cap_pc   = (state_q == ST_TWO) ? skid_pc_q   : if_pc_i;

  always_comb begin
    cap_immsel  = IMMSEL_NONE;
    cap_rd_we   = 1'b1;
    cap_illegal = 1'b0;
    unique case (cap_inst[6:2])
      OPC_LUI, OPC_AUIPC: cap_immsel = IMMSEL_U;
      OPC_JAL:            cap_immsel = IMMSEL_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM:
                          cap_immsel = IMMSEL_I;
      OPC_STORE: begin
        cap_immsel = IMMSEL_S;
        cap_rd_we  = 1'b0;
      end
      OPC_BRANCH: begin
        cap_immsel = IMMSEL_B;
        cap_rd_we  = 1'b0;
      end
      OPC_OP:             cap_immsel = IMMSEL_NONE;
      default: begin
        cap_illegal = 1'b1;
        cap_rd_we   = 1'b0;
      end
    endcase
    if (cap_inst[1:0] != 2'b11) begin
      cap_immsel  = IMMSEL_NONE;
      cap_rd_we   = 1'b0;
      cap_illegal = 1'b1;
    end
  end

  id_decode_stage_immgen #(.XLEN(XLEN)) u_immgen (
    .inst   (cap_inst),
    .immsel (cap_immsel),
    .imm    (cap_imm)
  );

  always_comb begin
    cap_payload         = '0;
    cap_payload.pc      = cap_pc;
    cap_payload.imm     = (cap_immsel == IMMSEL_NONE) ? ZERO_WORD : cap_imm;
    cap_payload.immsel  = cap_immsel;
    cap_payload.rs1     = cap_inst[19:15];
    cap_payload.rs2     = cap_inst[24:20];
    cap_payload.rd      = cap_inst[11:7];
    cap_payload.rd_we   = cap_rd_we;
    cap_payload.illegal = cap_illegal;
  end

  // NOTE: the two payload registers are reset because outputs must read 0 out of reset; larger storage would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
    end else begin
      if (load_out) out_q <= cap_payload;
      if (load_skid) begin
        skid_inst_q <= if_inst_i;
        skid_pc_q   <= if_pc_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_cnt_q <= '0;
    end else if (ex_valid && !ex_ready_i && !flush_i && (bp_cnt_q != '1)) begin
      bp_cnt_q <= bp_cnt_q + CNT_W'(1);
    end
  end

  assign id_ready_o   = id_ready;
  assign ex_valid_o   = ex_valid;
  assign ex_pc_o      = out_q.pc;
  assign ex_imm_o     = out_q.imm;
  assign ex_immsel_o  = out_q.immsel;
  assign ex_rs1_o     = out_q.rs1;
  assign ex_rs2_o     = out_q.rs2;
  assign ex_rd_o      = out_q.rd;
  assign ex_rd_we_o   = out_q.rd_we;
  assign ex_illegal_o = out_q.illegal;
  assign bp_cnt_o     = bp_cnt_q;

endmodule
